key_debouncer: RTL and testbench

//  Receive end of the board push-button interface. Takes raw active-low KEY inputs
//  (bouncy, asynchronous to CLOCK_50) and produces clean pressed levels and
//  one-cycle press/release pulses for lab top levels. Sits between the KEY pins and
//  all user logic; KEY[0] reset handling stays outside this block.

---
 rtl/key_debouncer_pkg.sv | 18 +
 rtl/key_debounce_chan.sv | 154 +++++++++++++++
 rtl/key_debouncer.sv | 37 +++
 tb/tb_key_debouncer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: channel FSM encodings and default debounce lengths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package key_debouncer_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_PEND   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_PEND = 2'd3
    } key_state_e;

    // Sim uses a short window; the board value is 10 ms at 50 MHz.
    localparam int DB_CYCLES_SIM   = 16;
    localparam int DB_CYCLES_BOARD = 500_000;
    localparam int CNT_W_DEFAULT   = 20;

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchroniser, debounce FSM, optional auto-repeat (KEY_REPEAT_EN).
// Latency: 2 + DB_CYCLES cycles from a clean raw edge to the registered pulse/level.
// Backpressure: none; pulses are single-cycle and unconditional.
module key_debounce_chan
    import key_debouncer_pkg::*;
#(
    parameter int DB_CYCLES    = DB_CYCLES_SIM,
    parameter int CNT_W        = CNT_W_DEFAULT,
    parameter int REPEAT_DELAY = 1024,
    parameter int REPEAT_RATE  = 256
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic key_raw_n_i,
    output logic pressed_o,
    output logic press_p_o,
    output logic release_p_o
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pressed_q, pressed_d;
    logic             press_p_q, press_p_d;
    logic             release_p_q, release_p_d;
    logic             key_dn;

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_FIRST    = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] REP_FIRST_M1 = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_RATE_M1  = CNT_W'(REPEAT_RATE - 1);

    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] rate_q, rate_d;
    logic             rep_fire;
`endif

    assign key_dn = ~sync2_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pressed_d   = pressed_q;
        press_p_d   = 1'b0;
        release_p_d = 1'b0;

        case (state_q)
            ST_RELEASED: begin
                if (key_dn) begin
                    state_d = ST_PRESS_PEND;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_PRESS_PEND: begin
                if (!key_dn) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = ST_HELD;
                    cnt_d     = '0;
                    pressed_d = 1'b1;
                    press_p_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!key_dn) begin
                    state_d = ST_RELEASE_PEND;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_RELEASE_PEND: begin
                if (key_dn) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d     = ST_RELEASED;
                    cnt_d       = '0;
                    pressed_d   = 1'b0;
                    release_p_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
            end
        endcase

`ifdef KEY_REPEAT_EN
        // Hold time is frozen while a release is pending so a bounce back to HELD resumes the count.
        hold_d   = hold_q;
        rate_d   = rate_q;
        rep_fire = 1'b0;
        if (state_q == ST_RELEASED || state_q == ST_PRESS_PEND) begin
            hold_d = '0;
            rate_d = '0;
        end else if (state_q == ST_HELD && key_dn) begin
            if (hold_q != '1) begin
                hold_d = hold_q + CNT_W'(1);
            end
            if (hold_q == REP_FIRST_M1) begin
                rep_fire = 1'b1;
                rate_d   = '0;
            end else if (hold_q >= REP_FIRST) begin
                if (rate_q == REP_RATE_M1) begin
                    rep_fire = 1'b1;
                    rate_d   = '0;
                end else begin
                    rate_d = rate_q + CNT_W'(1);
                end
            end
        end
        press_p_d = press_p_d | rep_fire;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= ST_RELEASED;
            cnt_q       <= '0;
            pressed_q   <= 1'b0;
            press_p_q   <= 1'b0;
            release_p_q <= 1'b0;
`ifdef KEY_REPEAT_EN
            hold_q      <= '0;
            rate_q      <= '0;
`endif
        end else begin
            sync1_q     <= key_raw_n_i;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pressed_q   <= pressed_d;
            press_p_q   <= press_p_d;
            release_p_q <= release_p_d;
`ifdef KEY_REPEAT_EN
            hold_q      <= hold_d;
            rate_q      <= rate_d;
`endif
        end
    end

    assign pressed_o   = pressed_q;
    assign press_p_o   = press_p_q;
    assign release_p_o = release_p_q;

endmodule

// File: rtl/key_debouncer.sv
// Push-button receive block: NUM_KEYS independent debounce channels; auto-repeat under KEY_REPEAT_EN.
// Latency: 2 + DB_CYCLES cycles from clean raw edge to pressed/press_p/release_p.
// Backpressure: none; outputs are levels and single-cycle pulses.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int NUM_KEYS     = 2,
    parameter int DB_CYCLES    = DB_CYCLES_SIM,
    parameter int CNT_W        = CNT_W_DEFAULT,
    parameter int REPEAT_DELAY = 1024,
    parameter int REPEAT_RATE  = 256
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_raw_n,
    output logic [NUM_KEYS-1:0] pressed,
    output logic [NUM_KEYS-1:0] press_p,
    output logic [NUM_KEYS-1:0] release_p
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        key_debounce_chan #(
            .DB_CYCLES    (DB_CYCLES),
            .CNT_W        (CNT_W),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_chan (
            .clk_i       (CLOCK_50),
            .rst_n_i     (reset_n),
            .key_raw_n_i (key_raw_n[i]),
            .pressed_o   (pressed[i]),
            .press_p_o   (press_p[i]),
            .release_p_o (release_p[i])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Randomised and directed bench for key_debouncer against a run-length reference model.
module tb_key_debouncer;

    localparam int NK = 2;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] raw;
    logic [NK-1:0] pressed, press_p, release_p;

    always #10 clk = ~clk;

    key_debouncer #(
        .NUM_KEYS     (NK),
        .DB_CYCLES    (DB),
        .CNT_W        (20),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .CLOCK_50  (clk),
        .reset_n   (rst_n),
        .key_raw_n (raw),
        .pressed   (pressed),
        .press_p   (press_p),
        .release_p (release_p)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: raw delayed two samples, a change is accepted after DB consecutive
    // samples opposite to the current stable level.
    int            m_s1[NK], m_s2[NK], m_stable[NK], m_run[NK], m_held[NK];
    logic [NK-1:0] e_pr, e_pp, e_rp;

    task automatic model_step();
        int samp_dn;
`ifdef KEY_REPEAT_EN
        bit was_held;
`endif
        for (int k = 0; k < NK; k++) begin
            e_pp[k] = 1'b0;
            e_rp[k] = 1'b0;
            if (!rst_n) begin
                m_s1[k] = 1; m_s2[k] = 1;
                m_stable[k] = 0; m_run[k] = 0; m_held[k] = 0;
            end else begin
                samp_dn = (m_s2[k] == 0) ? 1 : 0;
                m_s2[k] = m_s1[k];
                m_s1[k] = int'(raw[k]);
`ifdef KEY_REPEAT_EN
                was_held = (m_stable[k] == 1) && (m_run[k] == 0);
`endif
                if (samp_dn != m_stable[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DB) begin
                        m_stable[k] = 1 - m_stable[k];
                        m_run[k]  = 0;
                        m_held[k] = 0;
                        if (m_stable[k] == 1) e_pp[k] = 1'b1;
                        else                  e_rp[k] = 1'b1;
                    end
                end else begin
`ifdef KEY_REPEAT_EN
                    if (was_held) begin
                        m_held[k]++;
                        if (m_held[k] == RD || (m_held[k] > RD && (m_held[k] - RD) % RR == 0))
                            e_pp[k] = 1'b1;
                    end
`endif
                    m_run[k] = 0;
                end
            end
            e_pr[k] = (m_stable[k] == 1);
        end
    endtask

    // One clock: model the edge, compare outputs 1 time unit later, return at negedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("pressed",   pressed,   e_pr);
        chk("press_p",   press_p,   e_pp);
        chk("release_p", release_p, e_rp);
        chk("excl",      press_p & release_p, 0);
        @(negedge clk);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, cnt, seen, rel_seen, pct;
        int q[$];

        // 1: reset with keys released
        rst_n = 1'b0;
        raw   = 2'b11;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("reset_out", {pressed, press_p, release_p}, 0);

        // 2: single press latency
        raw[0] = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (press_p[0]) begin lat = i; break; end
        end
        chk("press_lat", lat, 6);
        chk("press_lvl", pressed[0], 1);
        tick();
        chk("press_1cyc", press_p[0], 0);
        raw[0] = 1'b1;
        repeat (10) tick();

        // 3: key 1 bouncing every 2 clocks
        cnt = 0; seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (i % 2 == 0) raw[1] = ~raw[1];
            tick();
            if (press_p[1] || release_p[1]) cnt++;
            if (pressed[1]) seen = 1;
        end
        chk("glitch_pulses", cnt, 0);
        chk("glitch_level", seen, 0);
        raw[1] = 1'b1;
        repeat (10) tick();

        // 4: simultaneous press and release
        raw = 2'b00;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (press_p != 0) begin lat = i; break; end
        end
        chk("both_press", press_p, 2'b11);
        repeat (40) tick();
        raw = 2'b11;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (release_p != 0) break;
        end
        chk("both_release", release_p, 2'b11);
        repeat (5) tick();

        // 5: reset while held
        raw[0] = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (press_p[0]) break;
        end
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        chk("rst_mid_lvl", pressed[0], 0);
        chk("rst_mid_rel", release_p[0], 0);
        rst_n = 1'b1;
        lat = -1; rel_seen = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (release_p[0]) rel_seen++;
            if (press_p[0]) begin lat = i; break; end
        end
        chk("rst_repress_lat", lat, 6);
        chk("rst_no_release", rel_seen, 0);
        raw[0] = 1'b1;
        repeat (12) tick();

        // 6: long hold, auto-repeat only with KEY_REPEAT_EN
        raw[0] = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (press_p[0]) q.push_back(i);
        end
`ifdef KEY_REPEAT_EN
        chk("rep_count", q.size(), 6);
        if (q.size() >= 4) begin
            chk("rep_first", q[1] - q[0], 20);
            chk("rep_second", q[2] - q[0], 28);
            chk("rep_third", q[3] - q[0], 36);
        end
`else
        chk("rep_count", q.size(), 1);
`endif
        raw[0] = 1'b1;
        repeat (12) tick();

        // 7: random bouncing, long holds and occasional resets
        pct = 6;
        for (int i = 0; i < 1600; i++) begin
            if (i % 200 == 0) pct = (pct == 6) ? 1 : 6;
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 99) < pct) raw[k] = ~raw[k];
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n = 1'b1;
        raw   = 2'b11;
        repeat (12) tick();
        chk("final_idle", pressed, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
